// File: rtl/ppfifo_write_arbiter_pkg.sv
// rtl/ppfifo_write_arbiter_pkg.sv - shared types and constants for the ppfifo write arbiter
// Purpose: FSM state encoding, ppfifo count width and the buffer-choice helper.
// Ports: none (package).
package ppfifo_write_arbiter_pkg;

   localparam int PPFIFO_COUNT_WIDTH = 24;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACQUIRE = 2'd1,
      WRITE   = 2'd2,
      RELEASE = 2'd3
   } arb_state_e;

   // Prefer the buffer not used last so packets land in alternating order;
   // fall back to the other one when only it is ready.
   function automatic logic pick_buffer(input logic [1:0] ready, input logic last_buf);
      return ready[!last_buf] ? !last_buf : last_buf;
   endfunction

endpackage

// File: rtl/ppfifo_write_arbiter_if.sv
// rtl/ppfifo_write_arbiter_if.sv - ppfifo write-port bundle
// Purpose: groups the ppfifo write-side signals.
// Ports (signals): write_ready[2], write_size[24] from the fifo;
//                  write_activate[2], write_strobe, write_data[DATA_WIDTH] to the fifo.
// Modports: master = arbiter side, slave = ppfifo side.
interface ppfifo_write_arbiter_if #(
   parameter int DATA_WIDTH = 8
);
   import ppfifo_write_arbiter_pkg::*;

   logic [1:0]                    write_ready;
   logic [PPFIFO_COUNT_WIDTH-1:0] write_size;
   logic [1:0]                    write_activate;
   logic                          write_strobe;
   logic [DATA_WIDTH-1:0]         write_data;

   modport master (
      input  write_ready, write_size,
      output write_activate, write_strobe, write_data
   );

   modport slave (
      output write_ready, write_size,
      input  write_activate, write_strobe, write_data
   );

endinterface

// File: rtl/ppfifo_write_arbiter_rr_select.sv
// rtl/ppfifo_write_arbiter_rr_select.sv - combinational round-robin picker
// Purpose: first set request at or after rr_ptr, wrapping modulo NUM_REQ.
// Ports: req[NUM_REQ] in, rr_ptr[IDX_W] in, winner[NUM_REQ] one-hot out, index[IDX_W] out.
module rr_select #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] winner,
   output logic [IDX_W-1:0]   index
);

   // Walk offsets from the far end back to zero so the closest set
   // request to rr_ptr is the last one written.
   always_comb begin
      winner = '0;
      index  = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req[(int'(rr_ptr) + k) % NUM_REQ]) begin
            winner = NUM_REQ'(1) << ((int'(rr_ptr) + k) % NUM_REQ);
            index  = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
         end
      end
   end

endmodule

// File: rtl/ppfifo_write_arbiter.sv
// rtl/ppfifo_write_arbiter.sv - shares one ppfifo write port among NUM_REQ producers
// Purpose: acquire a free buffer, round-robin grant a requester, forward its
//          strobes/data, release on done, req drop, full buffer or (optional) timeout.
// Ports: clk, rst_n (async active-low); req/req_done/req_strobe[NUM_REQ], req_data[NUM_REQ*DW];
//        grant[NUM_REQ], grant_space[24], busy; ff = ppfifo write port (master).
// Build option: ARB_TIMEOUT_EN adds an idle-cycle counter that forces release after TIMEOUT.
module ppfifo_write_arbiter
   import ppfifo_write_arbiter_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8
`ifdef ARB_TIMEOUT_EN
   ,
   parameter int TIMEOUT    = 255
`endif
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [NUM_REQ-1:0]               req,
   input  logic [NUM_REQ-1:0]               req_done,
   input  logic [NUM_REQ-1:0]               req_strobe,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
   output logic [NUM_REQ-1:0]               grant,
   output logic [PPFIFO_COUNT_WIDTH-1:0]    grant_space,
   output logic                             busy,
   ppfifo_write_arbiter_if.master           ff
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   arb_state_e                    state, state_nxt;
   logic [IDX_W-1:0]              rr_ptr, gidx, win_idx, rr_after;
   logic [NUM_REQ-1:0]            winner;
   logic                          buf_sel, last_buf;
   logic [PPFIFO_COUNT_WIDTH-1:0] word_cnt;
   logic                          accept, rel_now;
`ifdef ARB_TIMEOUT_EN
   logic [7:0]                    idle_cnt;
   logic                          timeout_hit;
`endif

   rr_select #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
      .req    (req),
      .rr_ptr (rr_ptr),
      .winner (winner),
      .index  (win_idx)
   );

   assign rr_after = (int'(gidx) == NUM_REQ - 1) ? '0 : gidx + 1'b1;
   assign busy     = (state != IDLE);

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      rel_now   = 1'b0;
`ifdef ARB_TIMEOUT_EN
      timeout_hit = 1'b0;
`endif
      case (state)
         IDLE:    if (|req && |ff.write_ready) state_nxt = ACQUIRE;
         // Requests may vanish between IDLE and ACQUIRE; then nothing is activated.
         ACQUIRE: state_nxt = (|req) ? WRITE : IDLE;
         WRITE: begin
            accept  = req_strobe[gidx] && (word_cnt < ff.write_size);
            rel_now = req_done[gidx] || !req[gidx] ||
                      (accept && (word_cnt + 24'd1 == ff.write_size));
`ifdef ARB_TIMEOUT_EN
            timeout_hit = !accept && (idle_cnt == 8'(TIMEOUT - 1));
            rel_now     = rel_now || timeout_hit;
`endif
            if (rel_now) state_nxt = RELEASE;
         end
         // Activate stays low here so the ppfifo sees the buffer as finished.
         RELEASE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ff.write_strobe = accept;
      ff.write_data   = '0;
      if (state == WRITE) ff.write_data = req_data[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant             <= '0;
         grant_space       <= '0;
         ff.write_activate <= 2'b00;
         last_buf          <= 1'b1;
         rr_ptr            <= '0;
         gidx              <= '0;
         buf_sel           <= 1'b0;
         word_cnt          <= '0;
`ifdef ARB_TIMEOUT_EN
         idle_cnt          <= '0;
`endif
      end else begin
         case (state)
            IDLE: if (state_nxt == ACQUIRE) buf_sel <= pick_buffer(ff.write_ready, last_buf);
            ACQUIRE: begin
               if (|req) begin
                  ff.write_activate <= {buf_sel, !buf_sel};
                  grant             <= winner;
                  gidx              <= win_idx;
               end
               word_cnt    <= '0;
               grant_space <= ff.write_size;
`ifdef ARB_TIMEOUT_EN
               idle_cnt    <= '0;
`endif
            end
            WRITE: begin
               if (accept) begin
                  word_cnt    <= word_cnt + 24'd1;
                  grant_space <= grant_space - 24'd1;
               end
`ifdef ARB_TIMEOUT_EN
               idle_cnt <= accept ? 8'd0 : idle_cnt + 8'd1;
`endif
               if (rel_now) begin
                  ff.write_activate <= 2'b00;
                  grant             <= '0;
                  last_buf          <= buf_sel;
                  rr_ptr            <= rr_after;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ppfifo_write_arbiter.sv
// tb/tb_ppfifo_write_arbiter.sv - directed self-checking bench for ppfifo_write_arbiter
module tb_ppfifo_write_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  req = '0;
   logic [3:0]  req_done = '0;
   logic [3:0]  req_strobe = '0;
   logic [31:0] req_data = '0;
   logic [3:0]  grant;
   logic [23:0] grant_space;
   logic        busy;
   logic [23:0] cur_size = 24'd16;
   int          n_assert = 0;
   int          n_fail = 0;

   ppfifo_write_arbiter_if #(.DATA_WIDTH(8)) ff_if ();

   ppfifo_write_arbiter #(
      .NUM_REQ    (4),
      .DATA_WIDTH (8)
`ifdef ARB_TIMEOUT_EN
      ,
      .TIMEOUT    (10)
`endif
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .req_done    (req_done),
      .req_strobe  (req_strobe),
      .req_data    (req_data),
      .grant       (grant),
      .grant_space (grant_space),
      .busy        (busy),
      .ff          (ff_if)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic reset_dut();
      rst_n      = 1'b0;
      req        = '0;
      req_done   = '0;
      req_strobe = '0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic set_words(input int k);
      for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = 8'((i << 4) | k);
   endtask

   // Starts in IDLE with req already set; ends back in IDLE.
   task automatic do_packet(input logic [3:0] eg, input logic [1:0] ea, input int nw, input int lane);
      tick();
      tick();
      chk("pkt_grant", 32'(grant), 32'(eg));
      chk("pkt_activate", 32'(ff_if.write_activate), 32'(ea));
      chk("pkt_space_start", 32'(grant_space), 32'(cur_size));
      for (int k = 0; k < nw; k++) begin
         set_words(k);
         req_strobe = req;
         #1;
         chk("pkt_strobe", 32'(ff_if.write_strobe), 32'd1);
         chk("pkt_data", 32'(ff_if.write_data), 32'((lane << 4) | k));
         tick();
      end
      req_strobe = '0;
      chk("pkt_space_end", 32'(grant_space), 32'(cur_size - 24'(nw)));
      req_done = req & ~eg;
      tick();
      req_done = '0;
      chk("pkt_foreign_done", 32'(ff_if.write_activate), 32'(ea));
      req_done = eg;
      tick();
      req_done = '0;
      chk("pkt_rel_activate", 32'(ff_if.write_activate), 32'd0);
      chk("pkt_rel_grant", 32'(grant), 32'd0);
      chk("pkt_rel_busy", 32'(busy), 32'd1);
      tick();
      chk("pkt_idle_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      ff_if.write_ready = 2'b11;
      ff_if.write_size  = 24'd16;
      tick();
      tick();
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_activate", 32'(ff_if.write_activate), 32'd0);
      chk("rst_space", 32'(grant_space), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_strobe", 32'(ff_if.write_strobe), 32'd0);
      rst_n = 1'b1;

      // Single requester: 5 words into buffer 0, then buffer 1, then a zero-length packet.
      req = 4'b0001;
      do_packet(4'b0001, 2'b01, 5, 0);
      do_packet(4'b0001, 2'b10, 2, 0);
      do_packet(4'b0001, 2'b01, 0, 0);

      // Round robin over 1011 with alternating buffers.
      reset_dut();
      req = 4'b1011;
      do_packet(4'b0001, 2'b01, 3, 0);
      do_packet(4'b0010, 2'b10, 3, 1);
      do_packet(4'b1000, 2'b01, 3, 3);
      do_packet(4'b0001, 2'b10, 3, 0);

      // Auto release on a 4-word buffer with 7 strobes offered.
      reset_dut();
      cur_size         = 24'd4;
      ff_if.write_size = 24'd4;
      req = 4'b0001;
      tick();
      tick();
      for (int k = 0; k < 7; k++) begin
         req_strobe = 4'b0001;
         #1;
         chk("full_strobe", 32'(ff_if.write_strobe), (k < 4) ? 32'd1 : 32'd0);
         chk("full_space", 32'(grant_space), (k < 4) ? 32'(4 - k) : 32'd0);
         chk("full_activate", 32'(ff_if.write_activate), (k < 4) ? 32'd1 : 32'd0);
         tick();
      end
      req_strobe = '0;
      req = '0;
      tick();
      tick();

      // No buffer ready, then buffer 1 becomes ready; req drop releases.
      reset_dut();
      cur_size          = 24'd16;
      ff_if.write_size  = 24'd16;
      ff_if.write_ready = 2'b00;
      req = 4'b0001;
      tick();
      tick();
      tick();
      chk("noready_busy", 32'(busy), 32'd0);
      chk("noready_grant", 32'(grant), 32'd0);
      chk("noready_activate", 32'(ff_if.write_activate), 32'd0);
      ff_if.write_ready = 2'b10;
      tick();
      chk("ready1_cycle1", 32'(ff_if.write_activate), 32'd0);
      tick();
      chk("ready1_cycle2", 32'(ff_if.write_activate), 32'b10);
      req = '0;
      tick();
      chk("reqdrop_activate", 32'(ff_if.write_activate), 32'd0);
      tick();

      // Asynchronous reset mid-packet, then a clean packet.
      reset_dut();
      ff_if.write_ready = 2'b11;
      req = 4'b0001;
      tick();
      tick();
      for (int k = 0; k < 2; k++) begin
         req_strobe = 4'b0001;
         tick();
      end
      #1;
      chk("pre_rst_strobe", 32'(ff_if.write_strobe), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("async_activate", 32'(ff_if.write_activate), 32'd0);
      chk("async_grant", 32'(grant), 32'd0);
      chk("async_strobe", 32'(ff_if.write_strobe), 32'd0);
      chk("async_space", 32'(grant_space), 32'd0);
      chk("async_busy", 32'(busy), 32'd0);
      req_strobe = '0;
      tick();
      rst_n = 1'b1;
      do_packet(4'b0001, 2'b01, 3, 0);

      // Silent granted requester.
      reset_dut();
      req = 4'b0001;
      tick();
      tick();
      chk("silent_activate", 32'(ff_if.write_activate), 32'b01);
`ifdef ARB_TIMEOUT_EN
      begin
         int n = 0;
         for (int c = 1; c <= 50; c++) begin
            tick();
            if (ff_if.write_activate == 2'b00) begin
               n = c;
               break;
            end
         end
         chk("timeout_cycles", 32'(n), 32'd10);
      end
`else
      repeat (100) tick();
      chk("silent_busy", 32'(busy), 32'd1);
      chk("silent_hold", 32'(ff_if.write_activate), 32'b01);
      chk("silent_grant", 32'(grant), 32'b0001);
`endif
      req = '0;
      tick();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
